// File: rtl/alu_op_sequencer.sv
// Initiator for the combinational 32-bit ALU: buffers tagged commands in a FIFO, drives registered
// operands for one cycle, captures result and flags, and returns a tagged response.
module alu_op_sequencer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [2:0]       i_cmd_op,
    input  logic [WIDTH-1:0] i_cmd_a,
    input  logic [WIDTH-1:0] i_cmd_b,
    input  logic [TAG_W-1:0] i_cmd_tag,
    output logic [WIDTH-1:0] o_alu_inp1,
    output logic [WIDTH-1:0] o_alu_inp2,
    output logic [2:0]       o_alu_sel,
    input  logic [WIDTH-1:0] i_alu_outp,
    input  logic             i_alu_overflow,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [WIDTH-1:0] o_rsp_data,
    output logic [TAG_W-1:0] o_rsp_tag,
    output logic             o_rsp_zero,
    output logic             o_rsp_ovf,
    output logic             o_busy
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned EntW = 3 + 2 * WIDTH + TAG_W;
    localparam logic [2:0]  SelAdd = 3'b101;

    typedef enum logic [1:0] {StIdle, StDrive, StResp} state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic [EntW-1:0]   r_fifo_mem [DEPTH];
    logic [PtrW-1:0]   r_wptr;
    logic [PtrW-1:0]   r_rptr;
    logic [CntW-1:0]   r_count;
    logic [WIDTH-1:0]  r_alu_inp1;
    logic [WIDTH-1:0]  r_alu_inp2;
    logic [2:0]        r_alu_sel;
    logic [TAG_W-1:0]  r_tag;
    logic [WIDTH-1:0]  r_rsp_data;
    logic [TAG_W-1:0]  r_rsp_tag;
    logic              r_rsp_zero;
    logic              r_rsp_ovf;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [EntW-1:0]   w_head;

    assign w_full  = (r_count == CntW'(DEPTH));
    assign w_empty = (r_count == '0);
    // Readiness comes only from the registered count, so a same-cycle pop never admits a push.
    assign o_cmd_ready = !w_full && !i_rst;
    assign w_push  = i_cmd_valid && o_cmd_ready;
    assign w_pop   = !w_empty && ((r_state == StIdle) || ((r_state == StResp) && i_rsp_ready));
    assign w_head  = r_fifo_mem[r_rptr];

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo_mem[r_wptr] <= {i_cmd_op, i_cmd_a, i_cmd_b, i_cmd_tag};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (!w_empty) w_state_next = StDrive;
            StDrive: w_state_next = StResp;
            StResp:  if (i_rsp_ready) w_state_next = w_empty ? StIdle : StDrive;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        o_rsp_valid = (r_state == StResp);
        o_busy      = (r_state != StIdle) || !w_empty;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_alu_inp1 <= '0;
            r_alu_inp2 <= '0;
            r_alu_sel  <= '0;
            r_tag      <= '0;
            r_rsp_data <= '0;
            r_rsp_tag  <= '0;
            r_rsp_zero <= 1'b0;
            r_rsp_ovf  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PtrW'(1);
                {r_alu_sel, r_alu_inp1, r_alu_inp2, r_tag} <= w_head;
            end
            r_count <= r_count + CntW'(w_push) - CntW'(w_pop);
            if (r_state == StDrive) begin
                r_rsp_data <= i_alu_outp;
                r_rsp_zero <= (i_alu_outp == '0);
                // Only ADD produces a meaningful overflow indication.
                r_rsp_ovf  <= (r_alu_sel == SelAdd) && i_alu_overflow;
                r_rsp_tag  <= r_tag;
            end
        end
    end

    assign o_alu_inp1 = r_alu_inp1;
    assign o_alu_inp2 = r_alu_inp2;
    assign o_alu_sel  = r_alu_sel;
    assign o_rsp_data = r_rsp_data;
    assign o_rsp_tag  = r_rsp_tag;
    assign o_rsp_zero = r_rsp_zero;
    assign o_rsp_ovf  = r_rsp_ovf;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU plus a response-queue model checked every cycle,
// with directed literal checks and randomized traffic.
module tb_alu_op_sequencer;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic [3:0]  cmd_tag;
    logic [31:0] alu_inp1;
    logic [31:0] alu_inp2;
    logic [2:0]  alu_sel;
    logic [31:0] alu_outp;
    logic        alu_overflow;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_tag;
    logic        rsp_zero;
    logic        rsp_ovf;
    logic        busy;

    logic        force_ovf = 1'b0;
    logic        mon_en = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_rsp = 0;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  tag;
        logic        zero;
        logic        ovf;
    } rsp_t;

    rsp_t exp_q[$];

    alu_op_sequencer #(.WIDTH(32), .DEPTH(DEPTH), .TAG_W(4)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_cmd_valid    (cmd_valid),
        .o_cmd_ready    (cmd_ready),
        .i_cmd_op       (cmd_op),
        .i_cmd_a        (cmd_a),
        .i_cmd_b        (cmd_b),
        .i_cmd_tag      (cmd_tag),
        .o_alu_inp1     (alu_inp1),
        .o_alu_inp2     (alu_inp2),
        .o_alu_sel      (alu_sel),
        .i_alu_outp     (alu_outp),
        .i_alu_overflow (alu_overflow),
        .o_rsp_valid    (rsp_valid),
        .i_rsp_ready    (rsp_ready),
        .o_rsp_data     (rsp_data),
        .o_rsp_tag      (rsp_tag),
        .o_rsp_zero     (rsp_zero),
        .o_rsp_ovf      (rsp_ovf),
        .o_busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_fn(input logic [2:0] s, input logic [31:0] a,
                                           input logic [31:0] b);
        case (s)
            3'd0: return ~a;
            3'd1: return a & b;
            3'd2: return a ^ b;
            3'd3: return a | b;
            3'd4: return a - 32'd1;
            3'd5: return a + b;
            3'd6: return a - b;
            default: return a + 32'd1;
        endcase
    endfunction

    function automatic logic add_ovf(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] s;
        s = a + b;
        return (a[31] == b[31]) && (s[31] != a[31]);
    endfunction

    function automatic logic true_ovf(input logic [2:0] s, input logic [31:0] a,
                                      input logic [31:0] b);
        logic [31:0] d;
        d = a - b;
        case (s)
            3'd4: return a == 32'h8000_0000;
            3'd5: return add_ovf(a, b);
            3'd6: return (a[31] != b[31]) && (d[31] != a[31]);
            3'd7: return a == 32'h7fff_ffff;
            default: return 1'b0;
        endcase
    endfunction

    // External ALU: overflow is asserted for any arithmetic overflow, or always when forced.
    always_comb begin
        alu_outp     = alu_fn(alu_sel, alu_inp1, alu_inp2);
        alu_overflow = force_ovf || true_ovf(alu_sel, alu_inp1, alu_inp2);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Negedge monitor: compare against the model, then apply events of the coming edge.
    always @(negedge clk) begin : monitor
        rsp_t e;
        if (mon_en) begin
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", {63'd0, rsp_valid}, 64'd0);
                end else begin
                    e = exp_q[0];
                    check("rsp_data", {32'd0, rsp_data}, {32'd0, e.data});
                    check("rsp_tag", {60'd0, rsp_tag}, {60'd0, e.tag});
                    check("rsp_zero", {63'd0, rsp_zero}, {63'd0, e.zero});
                    check("rsp_ovf", {63'd0, rsp_ovf}, {63'd0, e.ovf});
                end
            end
            check("busy", {63'd0, busy}, {63'd0, exp_q.size() != 0});
            if (rst) check("cmd_ready_rst", {63'd0, cmd_ready}, 64'd0);
            else if (exp_q.size() < DEPTH) check("cmd_ready_room", {63'd0, cmd_ready}, 64'd1);
            else if (exp_q.size() > DEPTH) check("cmd_ready_full", {63'd0, cmd_ready}, 64'd0);

            if (rst) begin
                exp_q.delete();
            end else begin
                if (rsp_valid && rsp_ready && exp_q.size() != 0) begin
                    void'(exp_q.pop_front());
                    n_rsp++;
                end
                if (cmd_valid && cmd_ready) begin
                    e.data = alu_fn(cmd_op, cmd_a, cmd_b);
                    e.tag  = cmd_tag;
                    e.zero = (e.data == 32'd0);
                    e.ovf  = (cmd_op == 3'd5) && (force_ovf || add_ovf(cmd_a, cmd_b));
                    exp_q.push_back(e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag, output int waited);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_tag   = tag;
        waited    = 0;
        @(negedge clk);
        while (!cmd_ready && waited < 100) begin
            waited++;
            @(negedge clk);
        end
        if (!cmd_ready) check("send_timeout", {63'd0, cmd_ready}, 64'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(output logic [31:0] d, output logic [3:0] t, output logic z,
                           output logic o);
        int n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("rsp_timeout", {63'd0, rsp_valid}, 64'd1);
        d = rsp_data;
        t = rsp_tag;
        z = rsp_zero;
        o = rsp_ovf;
        tick();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 300) begin
            n++;
            @(negedge clk);
        end
        check("idle_timeout", {63'd0, busy}, 64'd0);
        tick();
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 4))
            0: return 32'd0;
            1: return 32'h7fff_ffff;
            2: return 32'hffff_ffff;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int got;
        int last;
        int cyc;
        int base;
        bit acc;
        logic [31:0] d;
        logic [3:0]  t;
        logic        z;
        logic        o;

        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = '0;
        cmd_a = '0;
        cmd_b = '0;
        cmd_tag = '0;
        rsp_ready = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_outs", {alu_inp1, alu_inp2}, 64'd0);
        check("rst_sel_rsp", {22'd0, alu_sel, rsp_data, rsp_tag, rsp_zero, rsp_ovf}, 64'd0);
        check("post_rst_ready", {63'd0, cmd_ready}, 64'd1);
        mon_en = 1'b1;
        tick();

        // 1: ADD overflow and latency
        rsp_ready = 1'b1;
        send(3'd5, 32'h7fff_ffff, 32'h0000_0001, 4'd3, w);
        @(negedge clk);
        check("t1_valid_n1", {63'd0, rsp_valid}, 64'd0);
        @(negedge clk);
        check("t1_valid_n2", {63'd0, rsp_valid}, 64'd0);
        check("t1_drive_sel", {61'd0, alu_sel}, 64'd5);
        check("t1_drive_ops", {alu_inp1, alu_inp2}, 64'h7fff_ffff_0000_0001);
        @(negedge clk);
        check("t1_valid", {63'd0, rsp_valid}, 64'd1);
        check("t1_data", {32'd0, rsp_data}, 64'h8000_0000);
        check("t1_flags", {58'd0, rsp_tag, rsp_zero, rsp_ovf}, {58'd0, 4'd3, 1'b0, 1'b1});
        tick();
        wait_idle();
        rsp_ready = 1'b0;

        // 2: forced overflow is masked for non-ADD ops
        force_ovf = 1'b1;
        send(3'd6, 32'd5, 32'd5, 4'd1, w);
        get_rsp(d, t, z, o);
        check("t2_sub", {d, 28'd0, t}, {32'd0, 28'd0, 4'd1});
        check("t2_sub_flags", {62'd0, z, o}, 64'b10);
        send(3'd7, 32'hffff_ffff, 32'd0, 4'd2, w);
        get_rsp(d, t, z, o);
        check("t2_inc", {d, 28'd0, t}, {32'd0, 28'd0, 4'd2});
        check("t2_inc_flags", {62'd0, z, o}, 64'b10);
        force_ovf = 1'b0;

        // 3: NOT then DEC, in order
        send(3'd0, 32'h0f0f_0f0f, 32'd0, 4'd4, w);
        send(3'd4, 32'd0, 32'd0, 4'd5, w);
        get_rsp(d, t, z, o);
        check("t3_not", {d, 28'd0, t}, {32'hf0f0_f0f0, 28'd0, 4'd4});
        get_rsp(d, t, z, o);
        check("t3_dec", {d, 28'd0, t}, {32'hffff_ffff, 28'd0, 4'd5});
        wait_idle();

        // 4: capacity DEPTH+1, backpressure, in-order drain at one per two cycles
        for (int k = 0; k < 5; k++) begin
            send(3'd5, 32'(k * 16 + 1), 32'(k), 4'(k), w);
            check("t4_accept_wait", 64'(w), 64'd0);
        end
        cmd_valid = 1'b1;
        cmd_op = 3'd5;
        cmd_a = 32'd81;
        cmd_b = 32'd5;
        cmd_tag = 4'd5;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t4_full", {63'd0, cmd_ready}, 64'd0);
            check("t4_hold", {27'd0, rsp_valid, rsp_tag, rsp_data}, {27'd0, 1'b1, 4'd0, 32'd1});
            tick();
        end
        rsp_ready = 1'b1;
        got = 0;
        last = 0;
        cyc = 0;
        acc = 1'b0;
        while (got < 6 && cyc < 100) begin
            @(negedge clk);
            if (cmd_valid && cmd_ready) acc = 1'b1;
            if (rsp_valid) begin
                check("t4_order", {60'd0, rsp_tag}, 64'(got));
                if (got > 0) check("t4_gap", 64'(cyc - last), 64'd2);
                last = cyc;
                got++;
            end
            tick();
            if (acc) cmd_valid = 1'b0;
            cyc++;
        end
        check("t4_count", 64'(got), 64'd6);
        @(negedge clk);
        check("t4_busy_fall", {63'd0, busy}, 64'd0);
        tick();
        rsp_ready = 1'b0;

        // 5: full FIFO with a response handshake in the same cycle
        base = n_rsp;
        for (int k = 0; k < 5; k++) send(3'd2, 32'(k + 100), 32'h55, 4'(k + 8), w);
        cmd_valid = 1'b1;
        cmd_op = 3'd3;
        cmd_a = 32'h1234;
        cmd_b = 32'h4321;
        cmd_tag = 4'd13;
        @(negedge clk);
        check("t5_full", {62'd0, cmd_ready, rsp_valid}, 64'b01);
        tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        check("t5_no_pushthru", {63'd0, cmd_ready}, 64'd0);
        tick();
        rsp_ready = 1'b0;
        @(negedge clk);
        check("t5_next_ready", {63'd0, cmd_ready}, 64'd1);
        tick();
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_idle();
        check("t5_delivered", 64'(n_rsp - base), 64'd6);
        rsp_ready = 1'b0;

        // 6: reset during RESP with two queued
        for (int k = 0; k < 3; k++) send(3'd5, 32'(k), 32'd1, 4'(k + 1), w);
        cyc = 0;
        @(negedge clk);
        while (!rsp_valid && cyc < 50) begin
            cyc++;
            @(negedge clk);
        end
        check("t6_resp", {63'd0, rsp_valid}, 64'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t6_valid_busy", {62'd0, rsp_valid, busy}, 64'd0);
        check("t6_ops", {alu_inp1, alu_inp2}, 64'd0);
        check("t6_rsp", {22'd0, alu_sel, rsp_data, rsp_tag, rsp_zero, rsp_ovf}, 64'd0);
        check("t6_ready", {63'd0, cmd_ready}, 64'd1);
        rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            @(negedge clk);
            check("t6_no_stale", {63'd0, rsp_valid}, 64'd0);
        end
        tick();
        rsp_ready = 1'b0;
        send(3'd5, 32'd2, 32'd3, 4'd7, w);
        get_rsp(d, t, z, o);
        check("t6_add", {d, 28'd0, t}, {32'd5, 28'd0, 4'd7});
        wait_idle();

        // Randomized traffic, first with true overflow then with forced overflow
        for (int ph = 0; ph < 2; ph++) begin
            force_ovf = ph[0];
            for (int k = 0; k < 600; k++) begin
                rst       = ($urandom_range(0, 149) == 0);
                cmd_valid = ($urandom_range(0, 2) != 0);
                cmd_op    = 3'($urandom_range(0, 7));
                cmd_a     = pick();
                cmd_b     = pick();
                cmd_tag   = 4'($urandom_range(0, 15));
                rsp_ready = ($urandom_range(0, 3) != 0);
                tick();
            end
            rst = 1'b0;
            cmd_valid = 1'b0;
            rsp_ready = 1'b1;
            wait_idle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Initiator side of the 32-bit ALU operand/select interface: `inp1`, `inp2`, `sel_alu` out; `outp`, `overflow` back.
- Accepts tagged ALU commands on a valid/ready port and buffers them in a small FIFO.
- Drives each command onto the combinational ALU with registered, glitch-free operands, captures result plus flags, and returns a tagged response on a valid/ready port.
- Sits between the MIPS control/datapath issue logic and the ALU; the ALU itself is unchanged.

Parameters:
- WIDTH, 32, operand/result width (ALU is fixed at 32).
- DEPTH, 4, command FIFO entries; power of 2, ≥2.
- TAG_W, 4, width of the command/response tag.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  FIFO can accept.
- cmd_op  input  3  ALU select code.
- cmd_a  input  WIDTH  operand 1.
- cmd_b  input  WIDTH  operand 2.
- cmd_tag  input  TAG_W  command tag.
- alu_inp1  output  WIDTH  to ALU inp1.
- alu_inp2  output  WIDTH  to ALU inp2.
- alu_sel  output  3  to ALU sel_alu.
- alu_outp  input  WIDTH  ALU result.
- alu_overflow  input  1  ALU overflow.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts.
- rsp_data  output  WIDTH  captured result.
- rsp_tag  output  TAG_W  tag of the command.
- rsp_zero  output  1  result == 0.
- rsp_ovf  output  1  masked overflow.
- busy  output  1  work queued or in flight.

Behaviour:
- Clock and reset: one clock, `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - FIFO empty; state IDLE.
  - All registered outputs 0: `alu_inp1`, `alu_inp2`, `alu_sel`=000, `rsp_*`.
  - `busy`=0.
  - `cmd_ready`=0 while rst=1, and 1 on the first cycle after.
- Select encoding, passed through unchanged:
  - 000 NOT a; 001 AND; 010 XOR; 011 OR.
  - 100 DEC a; 101 ADD; 110 SUB a-b; 111 INC a.
- Command push:
  - Occurs on cmd_valid&cmd_ready.
  - `cmd_ready` = !full, computed from the registered count.
  - A pop in the same cycle does not open a slot for a push when full (no push-through).
- FSM states: IDLE, DRIVE, RESP.
- IDLE:
  - If FIFO is non-empty, pop the head into the `alu_*`/tag registers and go to DRIVE.
  - `alu_*` hold their last values; no toggling while idle.
- DRIVE:
  - Operands stay stable for one full cycle.
  - At the end of the cycle, register `rsp_data`=alu_outp, `rsp_zero`=(alu_outp==0), `rsp_ovf`=alu_overflow if sel==101 else 0, and `rsp_tag`.
  - Go to RESP.
- RESP:
  - `rsp_valid`=1; all `rsp_*` held stable until rsp_ready.
  - On handshake: if FIFO is non-empty, pop the next command and go to DRIVE; otherwise go to IDLE and drop `rsp_valid`.
- Latency:
  - Command accepted into an empty, idle unit at edge N → `rsp_valid` high after edge N+2.
  - Sustained throughput is 1 result per 2 cycles when rsp_ready is held at 1.
- Ordering: responses are strictly FIFO order.
- Capacity: max outstanding = DEPTH queued + 1 in flight.
- `busy` = (state!=IDLE) | (count!=0).
- Overflow masking: ADD is the only op whose overflow is meaningful; all other ops report 0 regardless of the `alu_overflow` level.
- Reset mid-operation: all queued and in-flight commands are discarded; no response is emitted; `rsp_valid` is 0 the cycle after rst.
- FIFO pointers: log2(DEPTH) bits, wrapping naturally; count is 0..DEPTH.

Test Plan:
1. ADD a=0x7FFFFFFF b=0x00000001 tag=3, rsp_ready=1; bench ALU model gives true signed overflow → rsp_data=0x80000000, rsp_ovf=1, rsp_zero=0, rsp_tag=3, rsp_valid 2 cycles after accept, alu_sel=101 during DRIVE.
2. SUB 5-5, with bench forcing alu_overflow=1 → rsp_data=0, rsp_zero=1, rsp_ovf=0. Then INC 0xFFFFFFFF → 0x00000000, zero=1, ovf=0.
3. NOT a=0x0F0F0F0F, then DEC a=0 → responses 0xF0F0F0F0 then 0xFFFFFFFF, in order.
4. rsp_ready=0; push tags 0..5 back-to-back:
   - tags 0..4 accepted (1 in flight + 4 queued); cmd_ready=0 on tag 5.
   - rsp_valid stays up with tag 0 and rsp_data unchanged.
   - Release rsp_ready → tags 0..5 delivered in order, one every 2 cycles; busy falls after the last.
5. FIFO full and RESP handshake in the same cycle with cmd_valid=1 → no push that cycle; push accepted the following cycle; no entry lost or duplicated.
6. Assert rst for 1 cycle during RESP with 2 commands queued → rsp_valid=0, busy=0, all outputs 0 next cycle; no stale responses after reset; a new ADD 2+3 returns 5.
